mulmod_arbiter: RTL and testbench

// - Shares one Montgomery modular multiplier (R = 2^PARAM_RLOG) between NUM_REQ requesters
//   (NTT butterfly, pointwise-mul, sampler units) inside the NTT accelerator.
// - Round-robin arbitration with per-requester valid/ready handshake.
// - Two-stage registered pipeline around the combinational reduction core.
// - Single tagged response port with backpressure; holds the shared modulus/qinv config.

---
 rtl/ntt_pkg.sv | 28 ++
 rtl/multiplier.sv | 44 ++++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/mulmod_arbiter.sv | 153 +++++++++++++++
 tb/tb_mulmod_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg
// Shared widths and pipeline payload types for the NTT accelerator's
// modular-multiplier datapath.
//   COEF_W      coefficient / modulus width
//   QINV_W      width of the -q^-1 mod 2^RLOG constant
//   RLOG_DEF    default Montgomery exponent (R = 2^RLOG_DEF)
//   NUM_REQ_DEF default number of requesters sharing the multiplier
//   REQ_ID_W    requester tag width carried through the pipeline
package ntt_pkg;

    localparam int COEF_W      = 16;
    localparam int QINV_W      = 18;
    localparam int RLOG_DEF    = 18;
    localparam int NUM_REQ_DEF = 4;
    localparam int REQ_ID_W    = $clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic [COEF_W-1:0]   in1;
        logic [COEF_W-1:0]   in2;
        logic [REQ_ID_W-1:0] id;
    } mul_req_t;

    typedef struct packed {
        logic [COEF_W-1:0]   result;
        logic [REQ_ID_W-1:0] id;
    } mul_rsp_t;

endpackage

// File: rtl/multiplier.sv
// multiplier
// Combinational Montgomery product: result = in1*in2*R^-1 mod q, R = 2^RLOG,
// fully reduced to [0, q). Operands are assumed to be below q.
//   in1_i, in2_i  operands
//   modulus_i     q
//   qinv_i        -q^-1 mod 2^RLOG
//   result_o      reduced product
module multiplier
    import ntt_pkg::*;
#(
    parameter int RLOG = RLOG_DEF
) (
    input  logic [COEF_W-1:0] in1_i,
    input  logic [COEF_W-1:0] in2_i,
    input  logic [COEF_W-1:0] modulus_i,
    input  logic [QINV_W-1:0] qinv_i,
    output logic [COEF_W-1:0] result_o
);

    localparam int A_W   = 2 * COEF_W;
    localparam int UQ_W  = RLOG + COEF_W;
    // a < 2^32 and u*q < 2^(RLOG+16): one carry bit covers the sum when RLOG >= 16.
    localparam int SUM_W = RLOG + COEF_W + 1;
    localparam int T_W   = COEF_W + 1;

    logic [A_W-1:0]   a;
    logic [RLOG-1:0]  u;
    logic [UQ_W-1:0]  uq;
    logic [SUM_W-1:0] sum;
    logic [T_W-1:0]   t;
    logic [T_W-1:0]   red;

    assign a   = A_W'(in1_i) * A_W'(in2_i);
    // Only the low RLOG bits of a*qinv matter.
    assign u   = RLOG'((A_W+QINV_W)'(a) * (A_W+QINV_W)'(qinv_i));
    assign uq  = UQ_W'(u) * UQ_W'(modulus_i);
    // a + u*q is an exact multiple of R, so the shift drops only zeros.
    assign sum = SUM_W'(a) + SUM_W'(uq);
    assign t   = T_W'(sum >> RLOG);
    // With operands below q, t < 2q, so a single conditional subtract suffices.
    assign red = (t >= T_W'(modulus_i)) ? (t - T_W'(modulus_i)) : t;
    assign result_o = COEF_W'(red);

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin selector: picks the first asserted request at or
// above ptr_i, wrapping around. Nothing is granted while en_i is low.
//   req_i        per-requester request vector
//   ptr_i        index with highest priority this cycle
//   en_i         grant enable
//   grant_o      one-hot grant (all zero when nothing granted)
//   grant_idx_o  index of the granted requester (0 when nothing granted)
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [ID_W:0] cand;
    logic          found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (en_i && !found && req_i[cand[ID_W-1:0]]) begin
                found                     = 1'b1;
                grant_o[cand[ID_W-1:0]]   = 1'b1;
                grant_idx_o               = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mulmod_arbiter.sv
// mulmod_arbiter
// Shares one Montgomery multiplier between NUM_REQ requesters through a
// round-robin arbiter and a two-stage pipeline (S0: operands, S1: result).
// Also holds the shared modulus / qinv configuration.
//   clk_i, rst_i            clock, synchronous active-high reset
//   cfg_we_i                config write (taken only when the pipeline is empty)
//   cfg_modulus_i/qinv_i    q and -q^-1 mod 2^PARAM_RLOG
//   cfg_busy_o              an operation is in flight
//   req_valid_i/ready_o     per-requester handshake; ready is the grant
//   req_in1_i/in2_i         packed operands, requester i at [16*i +: 16]
//   rsp_valid_o/ready_i     result handshake with backpressure
//   rsp_id_o, rsp_result_o  requester tag and reduced product
module mulmod_arbiter
    import ntt_pkg::*;
#(
    parameter  int NUM_REQ    = NUM_REQ_DEF,
    parameter  int PARAM_RLOG = RLOG_DEF,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_we_i,
    input  logic [COEF_W-1:0]         cfg_modulus_i,
    input  logic [QINV_W-1:0]         cfg_qinv_i,
    output logic                      cfg_busy_o,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*COEF_W-1:0] req_in1_i,
    input  logic [NUM_REQ*COEF_W-1:0] req_in2_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [COEF_W-1:0]         rsp_result_o
);

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    logic               s0_valid_q, s0_valid_d;
    mul_req_t           s0_q, s0_d;
    logic               s1_valid_q, s1_valid_d;
    mul_rsp_t           s1_q, s1_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [COEF_W-1:0]  modulus_q, modulus_d;
    logic [QINV_W-1:0]  qinv_q, qinv_d;

    logic               cfg_take;
    logic               s0_adv;
    logic               s1_adv;
    logic               arb_en;
    logic               grant_any;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W:0]      ptr_inc;
    logic [COEF_W-1:0]  core_result;

    logic [COEF_W-1:0]  in1_arr [NUM_REQ];
    logic [COEF_W-1:0]  in2_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign in1_arr[gi] = req_in1_i[COEF_W*gi +: COEF_W];
            assign in2_arr[gi] = req_in2_i[COEF_W*gi +: COEF_W];
        end
    endgenerate

    assign s1_adv   = !s1_valid_q || rsp_ready_i;
    assign s0_adv   = !s0_valid_q || s1_adv;
    assign cfg_take = cfg_we_i && !s0_valid_q && !s1_valid_q;
    // A config write owns the cycle; gating with reset keeps ready low while held in reset.
    assign arb_en   = s0_adv && !cfg_take && !rst_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i       (req_valid_i),
        .ptr_i       (rr_ptr_q),
        .en_i        (arb_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    multiplier #(
        .RLOG (PARAM_RLOG)
    ) u_mul (
        .in1_i     (s0_q.in1),
        .in2_i     (s0_q.in2),
        .modulus_i (modulus_q),
        .qinv_i    (qinv_q),
        .result_o  (core_result)
    );

    assign grant_any = |grant;
    assign ptr_inc   = {1'b0, grant_idx} + (ID_W+1)'(1);

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_d       = s0_q;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        rr_ptr_d   = rr_ptr_q;
        modulus_d  = modulus_q;
        qinv_d     = qinv_q;

        if (cfg_take) begin
            modulus_d = cfg_modulus_i;
            qinv_d    = cfg_qinv_i;
        end

        if (s1_adv) begin
            s1_valid_d  = s0_valid_q;
            s1_d.result = core_result;
            s1_d.id     = s0_q.id;
        end

        // S0 refills in the same cycle S1 drains, so full rate is one result per cycle.
        if (s0_adv) begin
            s0_valid_d = grant_any;
            if (grant_any) begin
                s0_d.in1 = in1_arr[grant_idx];
                s0_d.in2 = in2_arr[grant_idx];
                s0_d.id  = REQ_ID_W'(grant_idx);
                rr_ptr_d = (ptr_inc == NUM_REQ_W) ? '0 : ID_W'(ptr_inc);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_valid_q <= 1'b0;
            s0_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            rr_ptr_q   <= '0;
            modulus_q  <= '0;
            qinv_q     <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_q       <= s0_d;
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            rr_ptr_q   <= rr_ptr_d;
            modulus_q  <= modulus_d;
            qinv_q     <= qinv_d;
        end
    end

    assign req_ready_o  = grant;
    assign cfg_busy_o   = s0_valid_q || s1_valid_q;
    assign rsp_valid_o  = s1_valid_q;
    assign rsp_id_o     = ID_W'(s1_q.id);
    assign rsp_result_o = s1_q.result;

endmodule

// File: tb/tb_mulmod_arbiter.sv
// tb_mulmod_arbiter
// Self-checking bench for mulmod_arbiter. The reference model computes
// a*b*R^-1 mod q directly from modular arithmetic (R^-1 found by search) and
// a scoreboard holds expected responses in acceptance order.
module tb_mulmod_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cfg_we_i;
    logic [15:0] cfg_modulus_i;
    logic [17:0] cfg_qinv_i;
    logic        cfg_busy_o;
    logic [3:0]  req_valid_i;
    logic [3:0]  req_ready_o;
    logic [63:0] req_in1_i;
    logic [63:0] req_in2_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [1:0]  rsp_id_o;
    logic [15:0] rsp_result_o;

    mulmod_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_modulus_i (cfg_modulus_i),
        .cfg_qinv_i    (cfg_qinv_i),
        .cfg_busy_o    (cfg_busy_o),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_in1_i     (req_in1_i),
        .req_in2_i     (req_in2_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_id_o      (rsp_id_o),
        .rsp_result_o  (rsp_result_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cur_q;
    int cur_rinv;
    bit refill;
    int max_ones;

    int exp_id[$];
    int exp_res[$];
    int obs_id[$];
    int obs_res[$];
    int grant_log[$];

    logic [3:0]  s_ready;
    logic        s_rsp_valid;
    logic [1:0]  s_rsp_id;
    logic [15:0] s_rsp_result;
    logic        s_busy;

    // ---------------- reference model ----------------
    function automatic int mont_ref(int a, int b);
        longint p;
        p = (longint'(a) * longint'(b)) % cur_q;
        return int'((p * cur_rinv) % cur_q);
    endfunction

    task automatic set_model_q(int q);
        longint rm;
        cur_q = q;
        rm = (longint'(1) << 18) % q;
        for (int x = 1; x < q; x++) begin
            if ((rm * x) % q == 1) cur_rinv = x;
        end
    endtask

    function automatic int calc_qinv(int q);
        for (int x = 0; x < 262144; x++) begin
            if ((longint'(q) * x + 1) % 262144 == 0) return x;
        end
        return 0;
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic set_req(int i, int a, int b);
        req_valid_i[i]        = 1'b1;
        req_in1_i[16*i +: 16] = 16'(a);
        req_in2_i[16*i +: 16] = 16'(b);
    endtask

    function automatic int rnd_op();
        return int'($urandom_range(cur_q - 1, 0));
    endfunction

    // One clock: sample at negedge+1, record handshakes, advance to next negedge.
    task automatic cycle();
        logic [3:0] acc;
        int ones;
        #1;
        s_ready      = req_ready_o;
        s_rsp_valid  = rsp_valid_o;
        s_rsp_id     = rsp_id_o;
        s_rsp_result = rsp_result_o;
        s_busy       = cfg_busy_o;
        ones = $countones(req_ready_o);
        if (ones > max_ones) max_ones = ones;
        acc = req_valid_i & req_ready_o;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] === 1'b1) begin
                exp_id.push_back(i);
                exp_res.push_back(mont_ref(int'(req_in1_i[16*i +: 16]), int'(req_in2_i[16*i +: 16])));
                grant_log.push_back(i);
            end
        end
        if (rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
            obs_id.push_back(int'(rsp_id_o));
            obs_res.push_back(int'(rsp_result_o));
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (acc[i] === 1'b1) begin
                if (refill) set_req(i, rnd_op(), rnd_op());
                else req_valid_i[i] = 1'b0;
            end
        end
    endtask

    task automatic drain();
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (k >= 3 && obs_id.size() == exp_id.size() && req_valid_i == 4'b0) break;
            cycle();
        end
    endtask

    task automatic clear_sb();
        exp_id.delete(); exp_res.delete(); obs_id.delete(); obs_res.delete();
    endtask

    task automatic cfg_write(int q);
        cfg_we_i      = 1'b1;
        cfg_modulus_i = 16'(q);
        cfg_qinv_i    = 18'(calc_qinv(q));
        cycle();
        cfg_we_i      = 1'b0;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = '0;
        cycle();
        rst_i       = 1'b0;
        clear_sb();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i       = 1'b1;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 5, 7);
        cycle();
        cycle();
        total += 5;
        if (s_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%0d want=0", s_rsp_valid); end
        if (s_rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d want=0", s_rsp_id); end
        if (s_rsp_result !== 16'd0) begin bad++; $display("FAIL reset_rsp_result got=%0d want=0", s_rsp_result); end
        if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d want=0", s_busy); end
        if (s_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", s_ready); end
        do_reset();
        set_model_q(3329);
        cfg_write(3329);
        $display("test_reset done");
    endtask

    task automatic test_single();
        refill = 1'b0;
        rsp_ready_i = 1'b1;
        set_req(0, 1234, 2482);
        cycle();
        total++;
        if (s_ready !== 4'b0001) begin bad++; $display("FAIL single_accept got=%b want=0001", s_ready); end
        cycle();
        total += 2;
        if (s_rsp_valid !== 1'b0) begin bad++; $display("FAIL single_t1_valid got=%0d want=0", s_rsp_valid); end
        if (s_busy !== 1'b1) begin bad++; $display("FAIL single_t1_busy got=%0d want=1", s_busy); end
        cycle();
        total += 3;
        if (s_rsp_valid !== 1'b1) begin bad++; $display("FAIL single_t2_valid got=%0d want=1", s_rsp_valid); end
        if (s_rsp_id !== 2'd0) begin bad++; $display("FAIL single_t2_id got=%0d want=0", s_rsp_id); end
        if (s_rsp_result !== 16'd1234) begin bad++; $display("FAIL single_t2_result got=%0d want=1234", s_rsp_result); end
        drain();
        total++;
        if (obs_id.size() != 1) begin bad++; $display("FAIL single_count got=%0d want=1", obs_id.size()); end
        clear_sb();
        $display("test_single done");
    endtask

    task automatic test_boundary();
        refill = 1'b0;
        set_req(0, 3328, 2482);
        set_req(1, 0, 2482);
        set_req(2, 3328, 3328);
        set_req(3, 3328, 1);
        drain();
        total++;
        if (obs_id.size() != 4 || exp_id.size() != 4) begin
            bad++; $display("FAIL boundary_count got=%0d want=4", obs_id.size());
        end
        foreach (obs_id[k]) begin
            total++;
            if (k >= exp_id.size() || obs_id[k] !== exp_id[k] || obs_res[k] !== exp_res[k]) begin
                bad++; $display("FAIL boundary_rsp[%0d] got id=%0d res=%0d", k, obs_id[k], obs_res[k]);
            end
            total++;
            if (obs_res[k] >= 3329) begin bad++; $display("FAIL boundary_range got=%0d want <3329", obs_res[k]); end
            if (obs_id[k] == 0) begin
                total++;
                if (obs_res[k] !== 3328) begin bad++; $display("FAIL boundary_3328 got=%0d want=3328", obs_res[k]); end
            end
            if (obs_id[k] == 1) begin
                total++;
                if (obs_res[k] !== 0) begin bad++; $display("FAIL boundary_zero got=%0d want=0", obs_res[k]); end
            end
        end
        clear_sb();
        $display("test_boundary done");
    endtask

    task automatic test_round_robin();
        do_reset();
        cfg_write(3329);
        grant_log.delete();
        max_ones = 0;
        refill = 1'b1;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, rnd_op(), rnd_op());
        for (int c = 0; c < 8; c++) begin
            cycle();
            total++;
            if (s_ready !== 4'(1 << (c % 4))) begin
                bad++; $display("FAIL rr_grant_c%0d got=%b want=%b", c, s_ready, 4'(1 << (c % 4)));
            end
        end
        refill = 1'b0;
        drain();
        total += 2;
        if (max_ones > 1) begin bad++; $display("FAIL rr_onehot got=%0d want<=1", max_ones); end
        if (obs_id.size() != 12 || grant_log.size() != 12) begin
            bad++; $display("FAIL rr_count got=%0d grants=%0d want=12", obs_id.size(), grant_log.size());
        end
        foreach (obs_id[k]) begin
            total++;
            if (obs_id[k] !== (k % 4) || k >= exp_res.size() || obs_res[k] !== exp_res[k]) begin
                bad++; $display("FAIL rr_rsp[%0d] got id=%0d res=%0d want id=%0d", k, obs_id[k], obs_res[k], k % 4);
            end
        end
        clear_sb();
        $display("test_round_robin done");
    endtask

    task automatic test_backpressure();
        int a1, b1, want1;
        refill = 1'b0;
        rsp_ready_i = 1'b0;
        a1 = rnd_op(); b1 = rnd_op();
        want1 = mont_ref(a1, b1);
        set_req(1, a1, b1);
        set_req(2, rnd_op(), rnd_op());
        set_req(3, rnd_op(), rnd_op());
        cycle();
        cycle();
        for (int c = 0; c < 5; c++) begin
            cycle();
            total += 4;
            if (s_ready !== 4'b0) begin bad++; $display("FAIL bp_ready_c%0d got=%b want=0000", c, s_ready); end
            if (s_rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_c%0d got=%0d want=1", c, s_rsp_valid); end
            if (s_rsp_id !== 2'd1) begin bad++; $display("FAIL bp_id_c%0d got=%0d want=1", c, s_rsp_id); end
            if (s_rsp_result !== 16'(want1)) begin bad++; $display("FAIL bp_result_c%0d got=%0d want=%0d", c, s_rsp_result, want1); end
        end
        total++;
        if (exp_id.size() != 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", exp_id.size()); end
        drain();
        total++;
        if (obs_id.size() != 3 || exp_id.size() != 3) begin
            bad++; $display("FAIL bp_count got=%0d want=3", obs_id.size());
        end
        foreach (obs_id[k]) begin
            total++;
            if (obs_id[k] !== (k + 1) || k >= exp_res.size() || obs_res[k] !== exp_res[k]) begin
                bad++; $display("FAIL bp_rsp[%0d] got id=%0d res=%0d want id=%0d", k, obs_id[k], obs_res[k], k + 1);
            end
        end
        clear_sb();
        $display("test_backpressure done");
    endtask

    task automatic test_config_busy();
        int a, b;
        refill = 1'b0;
        rsp_ready_i = 1'b0;
        set_req(0, rnd_op(), rnd_op());
        cycle();
        cycle();
        cfg_we_i      = 1'b1;
        cfg_modulus_i = 16'd7681;
        cfg_qinv_i    = 18'(calc_qinv(7681));
        cycle();
        cfg_we_i = 1'b0;
        total++;
        if (s_busy !== 1'b1) begin bad++; $display("FAIL cfgbusy_busy got=%0d want=1", s_busy); end
        drain();
        // Issued after the ignored write: must still reduce modulo 3329.
        a = rnd_op(); b = rnd_op();
        set_req(2, a, b);
        drain();
        total++;
        if (obs_res.size() != 2 || obs_res[1] !== mont_ref(a, b)) begin
            bad++; $display("FAIL cfgbusy_ignored got=%0d want=%0d", obs_res.size() > 1 ? obs_res[1] : -1, mont_ref(a, b));
        end
        clear_sb();
        // Idle write with a pending request: the write wins the cycle.
        cfg_we_i      = 1'b1;
        cfg_modulus_i = 16'd7681;
        cfg_qinv_i    = 18'(calc_qinv(7681));
        set_req(1, rnd_op(), rnd_op());
        cycle();
        cfg_we_i = 1'b0;
        total++;
        if (s_ready !== 4'b0) begin bad++; $display("FAIL cfgidle_nogrant got=%b want=0000", s_ready); end
        set_model_q(7681);
        cycle();
        total++;
        if (s_ready !== 4'b0010) begin bad++; $display("FAIL cfgidle_grant got=%b want=0010", s_ready); end
        for (int i = 0; i < 4; i++) if (i != 1) set_req(i, rnd_op(), rnd_op());
        drain();
        total++;
        if (obs_id.size() != 4 || exp_id.size() != 4) begin bad++; $display("FAIL cfgidle_count got=%0d want=4", obs_id.size()); end
        foreach (obs_id[k]) begin
            total++;
            if (k >= exp_id.size() || obs_id[k] !== exp_id[k] || obs_res[k] !== exp_res[k]) begin
                bad++; $display("FAIL cfgidle_rsp[%0d] got id=%0d res=%0d", k, obs_id[k], obs_res[k]);
            end
        end
        clear_sb();
        $display("test_config_busy done");
    endtask

    task automatic test_reset_midstream();
        refill = 1'b0;
        rsp_ready_i = 1'b0;
        set_req(1, rnd_op(), rnd_op());
        set_req(2, rnd_op(), rnd_op());
        cycle();
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        clear_sb();
        rsp_ready_i = 1'b1;
        cycle();
        total += 2;
        if (s_rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0d want=0", s_rsp_valid); end
        if (s_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0d want=0", s_busy); end
        for (int c = 0; c < 4; c++) cycle();
        total++;
        if (obs_id.size() != 0) begin bad++; $display("FAIL midrst_discard got=%0d want=0", obs_id.size()); end
        set_model_q(3329);
        cfg_write(3329);
        for (int i = 0; i < 4; i++) set_req(i, rnd_op(), rnd_op());
        cycle();
        total++;
        if (s_ready !== 4'b0001) begin bad++; $display("FAIL midrst_ptr got=%b want=0001", s_ready); end
        drain();
        total++;
        if (obs_id.size() != 4 || exp_id.size() != 4) begin bad++; $display("FAIL midrst_count got=%0d want=4", obs_id.size()); end
        foreach (obs_id[k]) begin
            total++;
            if (obs_id[k] !== k || k >= exp_res.size() || obs_res[k] !== exp_res[k]) begin
                bad++; $display("FAIL midrst_rsp[%0d] got id=%0d res=%0d want id=%0d", k, obs_id[k], obs_res[k], k);
            end
        end
        clear_sb();
        $display("test_reset_midstream done");
    endtask

    task automatic test_random();
        refill = 1'b0;
        max_ones = 0;
        for (int c = 0; c < 300; c++) begin
            rsp_ready_i = ($urandom_range(9, 0) < 7);
            for (int i = 0; i < 4; i++) begin
                if (!req_valid_i[i] && $urandom_range(1, 0) == 1) set_req(i, rnd_op(), rnd_op());
            end
            cycle();
            if (s_rsp_valid === 1'b1) begin
                total++;
                if (int'(s_rsp_result) >= cur_q) begin bad++; $display("FAIL rand_range got=%0d want <%0d", s_rsp_result, cur_q); end
            end
        end
        drain();
        total += 2;
        if (max_ones > 1) begin bad++; $display("FAIL rand_onehot got=%0d want<=1", max_ones); end
        if (obs_id.size() != exp_id.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs_id.size(), exp_id.size()); end
        foreach (obs_id[k]) begin
            total++;
            if (k >= exp_id.size() || obs_id[k] !== exp_id[k] || obs_res[k] !== exp_res[k]) begin
                bad++; $display("FAIL rand_rsp[%0d] got id=%0d res=%0d", k, obs_id[k], obs_res[k]);
            end
        end
        $display("test_random done: %0d responses", obs_id.size());
        clear_sb();
    endtask

    initial begin
        rst_i         = 1'b1;
        cfg_we_i      = 1'b0;
        cfg_modulus_i = '0;
        cfg_qinv_i    = '0;
        req_valid_i   = '0;
        req_in1_i     = '0;
        req_in2_i     = '0;
        rsp_ready_i   = 1'b1;
        refill        = 1'b0;
        max_ones      = 0;
        set_model_q(3329);
        @(negedge clk);
        test_reset();
        test_single();
        test_boundary();
        test_round_robin();
        test_backpressure();
        test_config_busy();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
